// File: rtl/snake_move_if.sv
// Bundles the snake_move control, status and renderer-query signals.
// Latency: none (wires only).
// Backpressure: none; every signal is a level or a one-cycle pulse.
// master: game controller / renderer side; slave: snake_move.
interface snake_move_if;
    logic       start;      // one-cycle (re)start pulse
    logic [1:0] dir_req;    // 00 up, 01 right, 10 down, 11 left
    logic       dir_valid;  // dir_req qualifier
    logic       eat;        // apple eaten pulse
    logic [6:0] query_x;    // renderer cell column
    logic [5:0] query_y;    // renderer cell row
    logic [6:0] head_x;     // registered head column
    logic [5:0] head_y;     // registered head row
    logic [4:0] length;     // active segment count
    logic       move_tick;  // pulse when the head takes a new value
    logic       running;    // high in RUN
    logic       game_over;  // high in OVER
    logic       body_on;    // query cell occupied, 1-cycle latency

    modport master (
        output start, dir_req, dir_valid, eat, query_x, query_y,
        input  head_x, head_y, length, move_tick, running, game_over, body_on
    );

    modport slave (
        input  start, dir_req, dir_valid, eat, query_x, query_y,
        output head_x, head_y, length, move_tick, running, game_over, body_on
    );
endinterface

// File: rtl/snake_move.sv
// Snake position/motion: head steps one cell per game tick, body buffer, growth, collisions.
// Latency: head/move_tick update on the tick edge; body_on is one cycle after the query.
// Backpressure: none; inputs are pulses sampled every cycle, outputs are free-running.
// Ports: clk, reset_n (async, active low), bus (snake_move_if.slave: control in, head/status/query out).
module snake_move #(
    parameter int GRID_COLS = 64,
    parameter int GRID_ROWS = 48,
    parameter int TICK_DIV  = 4000000,
    parameter int MAX_LEN   = 16,
    parameter int INIT_LEN  = 3,
    parameter int START_X   = 14,
    parameter int START_Y   = 33
) (
    input  logic         clk,
    input  logic         reset_n,
    snake_move_if.slave  bus
);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_OVER} state_t;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_RIGHT = 2'd1;
    localparam logic [1:0] DIR_DOWN  = 2'd2;
    localparam logic [1:0] DIR_LEFT  = 2'd3;
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    // Initial body lies horizontally to the left of the start cell.
    function automatic logic [6:0] init_x(input int i);
        return 7'(START_X - i);
    endfunction

    state_t        state_q, state_d;
    logic [6:0]    seg_x_q [MAX_LEN];
    logic [6:0]    seg_x_d [MAX_LEN];
    logic [5:0]    seg_y_q [MAX_LEN];
    logic [5:0]    seg_y_d [MAX_LEN];
    logic [4:0]    length_q, length_d;
    logic [1:0]    dir_q, dir_d;
    logic [1:0]    pending_dir_q, pending_dir_d;
    logic          grow_pending_q, grow_pending_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          move_tick_q, move_tick_d;
    logic          body_on_q, body_on_d;

    // Next-head candidate, one bit wider so 0-1 lands far out of range.
    logic [7:0]    next_x;
    logic [6:0]    next_y;
    logic          wall_hit;
    logic          self_hit;
    logic          grow_eff;
    logic [4:0]    check_lim;
    logic          tick_done;

    always_comb begin
        next_x = {1'b0, seg_x_q[0]};
        next_y = {1'b0, seg_y_q[0]};
        case (pending_dir_q)
            DIR_UP:    next_y = {1'b0, seg_y_q[0]} - 7'd1;
            DIR_RIGHT: next_x = {1'b0, seg_x_q[0]} + 8'd1;
            DIR_DOWN:  next_y = {1'b0, seg_y_q[0]} + 7'd1;
            default:   next_x = {1'b0, seg_x_q[0]} - 8'd1;
        endcase
        wall_hit = (next_x >= 8'(GRID_COLS)) || (next_y >= 7'(GRID_ROWS));

        // Growth only counts if there is room; otherwise the tail still vacates.
        grow_eff  = (grow_pending_q || bus.eat) && (length_q < 5'(MAX_LEN));
        check_lim = grow_eff ? length_q : (length_q - 5'd1);
        self_hit  = 1'b0;
        for (int i = 1; i < MAX_LEN; i++) begin
            if ((5'(i) < check_lim) &&
                (seg_x_q[i] == next_x[6:0]) && (seg_y_q[i] == next_y[5:0])) begin
                self_hit = 1'b1;
            end
        end

        tick_done = (cnt_q == CW'(TICK_DIV - 1));
    end

    always_comb begin
        state_d        = state_q;
        seg_x_d        = seg_x_q;
        seg_y_d        = seg_y_q;
        length_d       = length_q;
        dir_d          = dir_q;
        pending_dir_d  = pending_dir_q;
        grow_pending_d = grow_pending_q;
        cnt_d          = cnt_q;
        move_tick_d    = 1'b0;

        // Reverse of the current heading differs only in bit 1.
        if (bus.dir_valid && (bus.dir_req != (dir_q ^ 2'b10))) begin
            pending_dir_d = bus.dir_req;
        end

        case (state_q)
            ST_RUN: begin
                if (bus.eat) begin
                    grow_pending_d = 1'b1;
                end
                if (tick_done) begin
                    cnt_d = '0;
                    if (wall_hit || self_hit) begin
                        state_d = ST_OVER;
                    end else begin
                        for (int i = 1; i < MAX_LEN; i++) begin
                            seg_x_d[i] = seg_x_q[i-1];
                            seg_y_d[i] = seg_y_q[i-1];
                        end
                        seg_x_d[0]     = next_x[6:0];
                        seg_y_d[0]     = next_y[5:0];
                        move_tick_d    = 1'b1;
                        dir_d          = pending_dir_q;
                        grow_pending_d = 1'b0;
                        if (grow_eff) begin
                            length_d = length_q + 5'd1;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                // IDLE and OVER: a start pulse reinitialises everything.
                if (bus.start) begin
                    state_d = ST_RUN;
                    for (int i = 0; i < MAX_LEN; i++) begin
                        seg_x_d[i] = init_x(i);
                        seg_y_d[i] = 6'(START_Y);
                    end
                    length_d       = 5'(INIT_LEN);
                    dir_d          = DIR_RIGHT;
                    pending_dir_d  = DIR_RIGHT;
                    grow_pending_d = 1'b0;
                    cnt_d          = '0;
                end
            end
        endcase
    end

    // Renderer lookup against the current (possibly frozen) body.
    always_comb begin
        body_on_d = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if ((5'(i) < length_q) &&
                (seg_x_q[i] == bus.query_x) && (seg_y_q[i] == bus.query_y)) begin
                body_on_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x_q[i] <= init_x(i);
                seg_y_q[i] <= 6'(START_Y);
            end
            length_q       <= 5'(INIT_LEN);
            dir_q          <= DIR_RIGHT;
            pending_dir_q  <= DIR_RIGHT;
            grow_pending_q <= 1'b0;
            cnt_q          <= '0;
            move_tick_q    <= 1'b0;
            body_on_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            seg_x_q        <= seg_x_d;
            seg_y_q        <= seg_y_d;
            length_q       <= length_d;
            dir_q          <= dir_d;
            pending_dir_q  <= pending_dir_d;
            grow_pending_q <= grow_pending_d;
            cnt_q          <= cnt_d;
            move_tick_q    <= move_tick_d;
            body_on_q      <= body_on_d;
        end
    end

    assign bus.head_x    = seg_x_q[0];
    assign bus.head_y    = seg_y_q[0];
    assign bus.length    = length_q;
    assign bus.move_tick = move_tick_q;
    assign bus.running   = (state_q == ST_RUN);
    assign bus.game_over = (state_q == ST_OVER);
    assign bus.body_on   = body_on_q;

endmodule

// File: tb/tb_snake_move.sv
// Directed bench for snake_move with TICK_DIV=4; moves are checked by a scoreboard monitor.
module tb_snake_move;

    logic clk;
    logic reset_n;
    int   cyc;
    int   checks;
    int   errors;

    snake_move_if bus();

    snake_move #(
        .GRID_COLS(64), .GRID_ROWS(48), .TICK_DIV(4), .MAX_LEN(16),
        .INIT_LEN(3), .START_X(14), .START_Y(33)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        int c;
        int x;
        int y;
        int len;
    } exp_t;

    exp_t sb[$];

    localparam int K_START = 0;
    localparam int K_EAT   = 1;
    localparam int K_DIR   = 2;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: every move_tick must match the next queued move.
    always @(negedge clk) begin
        if (reset_n && bus.move_tick) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL move_unexpected: got move at cycle %0d head (%0d,%0d) len %0d, required no move",
                         cyc, bus.head_x, bus.head_y, bus.length);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (cyc != e.c || int'(bus.head_x) != e.x || int'(bus.head_y) != e.y ||
                    int'(bus.length) != e.len) begin
                    errors++;
                    $display("FAIL move: got cycle %0d head (%0d,%0d) len %0d, required cycle %0d head (%0d,%0d) len %0d",
                             cyc, bus.head_x, bus.head_y, bus.length, e.c, e.x, e.y, e.len);
                end
            end
        end
    end

    function automatic void push(input int c, input int x, input int y, input int len);
        exp_t e;
        e.c = c; e.x = x; e.y = y; e.len = len;
        sb.push_back(e);
    endfunction

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Return just after posedge number c.
    task automatic wait_to(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Hold a pulse so that it is sampled on posedge number c.
    task automatic pulse(input int c, input int kind, input logic [1:0] d);
        wait_to(c - 1);
        case (kind)
            K_START: bus.start = 1'b1;
            K_EAT:   bus.eat   = 1'b1;
            default: begin bus.dir_req = d; bus.dir_valid = 1'b1; end
        endcase
        wait_to(c);
        bus.start     = 1'b0;
        bus.eat       = 1'b0;
        bus.dir_valid = 1'b0;
    endtask

    task automatic chk_status(input string tag, input int x, input int y, input int len,
                              input int run, input int over);
        chk({tag, "_head_x"},    int'(bus.head_x),    x);
        chk({tag, "_head_y"},    int'(bus.head_y),    y);
        chk({tag, "_length"},    int'(bus.length),    len);
        chk({tag, "_running"},   int'(bus.running),   run);
        chk({tag, "_game_over"}, int'(bus.game_over), over);
    endtask

    initial begin
        int c0, c1, c2;
        checks = 0;
        errors = 0;
        reset_n       = 1'b0;
        bus.start     = 1'b0;
        bus.dir_req   = 2'd1;
        bus.dir_valid = 1'b0;
        bus.eat       = 1'b0;
        bus.query_x   = 7'd0;
        bus.query_y   = 6'd0;

        repeat (3) @(posedge clk);
        #1;
        chk_status("reset", 14, 33, 3, 0, 0);
        chk("reset_move_tick", int'(bus.move_tick), 0);
        chk("reset_body_on",   int'(bus.body_on),   0);
        reset_n = 1'b1;

        // Free run: a move every 4 cycles, first one 4 cycles after start.
        c0 = cyc + 2;
        push(c0 + 4,  15, 33, 3);
        push(c0 + 8,  16, 33, 3);
        push(c0 + 12, 17, 33, 3);
        // Reverse (left) dropped, up taken.
        push(c0 + 16, 17, 32, 3);
        // Eat between ticks, then eat coincident with a move, then no growth.
        push(c0 + 20, 17, 31, 4);
        push(c0 + 24, 17, 30, 5);
        push(c0 + 28, 17, 29, 5);
        // Turn right and run into the right wall.
        for (int k = 0; k < 46; k++) push(c0 + 32 + 4 * k, 18 + k, 29, 5);

        pulse(c0, K_START, 2'd0);
        chk("start_running", int'(bus.running), 1);
        pulse(c0 + 13, K_DIR, 2'd3);
        pulse(c0 + 14, K_DIR, 2'd0);
        pulse(c0 + 17, K_EAT, 2'd0);
        pulse(c0 + 24, K_EAT, 2'd0);
        pulse(c0 + 29, K_DIR, 2'd1);
        // Start while running must be ignored.
        pulse(c0 + 102, K_START, 2'd0);

        wait_to(c0 + 216);
        chk_status("wall", 63, 29, 5, 0, 1);
        bus.query_x = 7'd61; bus.query_y = 6'd29;
        wait_to(c0 + 217);
        chk("over_body_on_frozen", int'(bus.body_on), 1);
        bus.query_x = 7'd58;
        wait_to(c0 + 218);
        chk("over_body_on_past_tail", int'(bus.body_on), 0);
        bus.query_x = 7'd13; bus.query_y = 6'd33;

        // Restart, query, grow to 5, then loop back into the body.
        c1 = c0 + 220;
        push(c1 + 4,  15, 33, 4);
        push(c1 + 8,  16, 33, 5);
        push(c1 + 12, 16, 32, 5);
        push(c1 + 16, 15, 32, 5);
        pulse(c1, K_START, 2'd0);
        chk_status("restart", 14, 33, 3, 1, 0);
        pulse(c1 + 1, K_EAT, 2'd0);
        chk("query_13_33", int'(bus.body_on), 1);
        bus.query_x = 7'd11;
        wait_to(c1 + 2);
        chk("query_11_33", int'(bus.body_on), 0);
        pulse(c1 + 5,  K_EAT, 2'd0);
        pulse(c1 + 9,  K_DIR, 2'd0);
        pulse(c1 + 13, K_DIR, 2'd3);
        pulse(c1 + 17, K_DIR, 2'd2);
        wait_to(c1 + 20);
        chk_status("self_hit", 15, 32, 5, 0, 1);

        // Same loop at length 4: the head takes the cell the tail vacates.
        c2 = c1 + 24;
        push(c2 + 4,  15, 33, 4);
        push(c2 + 8,  15, 32, 4);
        push(c2 + 12, 14, 32, 4);
        push(c2 + 16, 14, 33, 4);
        push(c2 + 20, 14, 34, 4);
        pulse(c2, K_START, 2'd0);
        pulse(c2 + 1,  K_EAT, 2'd0);
        pulse(c2 + 5,  K_DIR, 2'd0);
        pulse(c2 + 9,  K_DIR, 2'd3);
        pulse(c2 + 13, K_DIR, 2'd2);
        wait_to(c2 + 20);
        chk_status("tail_chase", 14, 34, 4, 1, 0);

        // Asynchronous reset mid-run, checked between clock edges.
        bus.query_x = 7'd14; bus.query_y = 6'd34;
        wait_to(c2 + 22);
        #2;
        reset_n = 1'b0;
        #1;
        chk_status("midrun_reset", 14, 33, 3, 0, 0);
        chk("midrun_reset_move_tick", int'(bus.move_tick), 0);
        chk("midrun_reset_body_on",   int'(bus.body_on),   0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("idle_no_move_head_x", int'(bus.head_x), 14);
        chk("scoreboard_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/snake_move.md
Name: snake_move

Overview:
- Upstream stage of the apple/score block.
- Owns snake position and motion on the playfield grid. Advances the head one cell per game tick in the latched direction, keeps a body segment buffer, grows on the apple block's eat pulse, and detects wall and self collisions.
- Exports grid-coordinate head_x/head_y to the apple block and a per-cell body hit flag to the renderer.

Parameters:
- GRID_COLS, 64, playfield width in cells; legal x is 0..GRID_COLS-1 (≤128).
- GRID_ROWS, 48, playfield height in cells; legal y is 0..GRID_ROWS-1 (≤64).
- TICK_DIV, 4000000, clk cycles per move (10 moves/s at 40 MHz).
- MAX_LEN, 16, body buffer depth in segments, including the head.
- INIT_LEN, 3, length after reset and after each start.
- START_X, 14, initial head column.
- START_Y, 33, initial head row.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; (re)starts the game from IDLE or OVER.
- dir_req  in  2  requested direction: 00 up, 01 right, 10 down, 11 left.
- dir_valid  in  1  dir_req qualifier, one-cycle pulse.
- eat  in  1  one-cycle pulse from the apple block: apple eaten.
- query_x  in  7  renderer cell column.
- query_y  in  6  renderer cell row.
- head_x  out  7  head column, registered.
- head_y  out  6  head row, registered.
- length  out  5  active segment count (INIT_LEN..MAX_LEN).
- move_tick  out  1  one-cycle pulse on the edge where head_x/head_y take a new value.
- running  out  1  high in RUN.
- game_over  out  1  high in OVER.
- body_on  out  1  query cell is occupied by an active segment; 1-cycle latency.

Behaviour:
- States:
  - IDLE (reset state).
  - RUN: entered from IDLE or OVER on start. Start is ignored while in RUN.
  - OVER: entered from RUN on a collision. Stays until start.
- Reset (async, reset_n=0), and reinit on a start that is honoured:
  - seg[i] = (START_X-i, START_Y) for i < MAX_LEN.
  - length=INIT_LEN, dir=right, pending_dir=right, grow_pending=0, tick counter=0.
  - Outputs after reset: head_x=START_X, head_y=START_Y, move_tick=0, running=0, game_over=0, body_on=0.
- Direction:
  - dir_valid in any state loads pending_dir, unless the request is the exact reverse of the current dir; reverse requests are dropped.
  - If several requests arrive within one tick, the last accepted one wins.
  - pending_dir becomes dir only at a move.
- Tick:
  - The counter runs only in RUN and counts 0..TICK_DIV-1.
  - At the terminal count it wraps to 0 and a move is evaluated on that edge. First move occurs TICK_DIV cycles after entering RUN.
- Move evaluation:
  - next = seg[0] stepped one cell in pending_dir. Arithmetic is done one bit wider than the coordinate so that 0-1 is detected as out of range and does not wrap.
  - Wall: next x<0, x≥GRID_COLS, y<0 or y≥GRID_ROWS -> go to OVER. seg, length and head outputs are unchanged, and move_tick is not pulsed.
  - Self: next equals seg[i] for i in 1..length-1 -> OVER, with the same hold rules. The tail seg[length-1] is excluded when not growing, because it vacates this tick; it is included when growing.
  - Otherwise:
    - seg[i] <= seg[i-1] for all i; seg[0] <= next; head_x/head_y = next.
    - move_tick=1 for that cycle.
    - If grow_pending=1 or eat=1 on this edge: length = min(length+1, MAX_LEN) and grow_pending clears.
    - At MAX_LEN, further growth is silently dropped.
- Eat:
  - eat sets grow_pending in RUN; it is ignored in IDLE and OVER.
  - An eat on the same edge as a move is applied to that move and leaves grow_pending=0.
  - Multiple eats between ticks count once.
- Query:
  - body_on is registered. It is 1 if (query_x,query_y) matches any seg[i] with i < length, in any state, so the renderer shows the frozen snake in OVER.
- Reset asserted mid-game: immediate return to IDLE with reinit values. No pending state survives.

Test Plan:
- Reset, start, TICK_DIV=4, no input -> move_tick every 4 cycles; head_x 15,16,17, head_y=33, length=3.
- In RUN heading right, dir_valid with dir_req=11 (reverse), then dir_req=00 -> reverse dropped; next move gives head (x,32).
- eat pulse between ticks, then a second eat coincident with the following move -> length 3->4 on the first move, 4->5 on the second, grow_pending=0 afterwards.
- Head at x=GRID_COLS-1 heading right -> at the next tick game_over=1, running=0, head unchanged, no move_tick; start -> head (14,33), length 3, RUN.
- Grow to length 5, then steer up, left, down -> head re-enters its own body; OVER on that tick. The same loop at length 4 chasing the tail does not collide.
- query (13,33) right after start -> body_on=1 one cycle later; query (11,33) -> 0; reset_n low mid-run -> outputs at reset values immediately.
